// File: rtl/enc_8b10b_wide.sv
// rtl/enc_8b10b_wide.sv - multi-lane flow-controlled 8b/10b encoder, two-stage pipeline
// Optional invalid-K detection is compiled in with ENC_8B10B_WIDE_KERR_EN.
module enc_8b10b_wide #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NBYTES-1:0]   s_data,
  input  logic [NBYTES-1:0]     s_k,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [10*NBYTES-1:0]  m_data,
  output logic [NBYTES-1:0]     m_k_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  rdisp
);

  logic [8*NBYTES-1:0]  data_a;
  logic [NBYTES-1:0]    k_a;
  logic                 valid_a;
  logic                 rd;
  logic                 adv_b;
  logic                 xfer;
  logic                 load_a;
  logic [NBYTES:0]      disp_chain;
  logic [10*NBYTES-1:0] enc_data;

  assign adv_b   = !m_valid || m_ready;
  assign xfer    = valid_a && adv_b;
  assign s_ready = !valid_a || adv_b;
  assign load_a  = s_valid && s_ready;
  assign rdisp   = rd;

  // Disparity ripples lane 0 -> lane NBYTES-1, then carries into the next beat via rd.
  assign disp_chain[0] = rd;

  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    encode u_encode (
      .datain  ({k_a[i], data_a[8*i +: 8]}),
      .dispin  (disp_chain[i]),
      .dataout (enc_data[10*i +: 10]),
      .dispout (disp_chain[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_a  <= '0;
      k_a     <= '0;
      valid_a <= 1'b0;
    end else if (load_a) begin
      data_a  <= s_data;
      k_a     <= s_k;
      valid_a <= 1'b1;
    end else if (xfer) begin
      valid_a <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      rd      <= 1'b0;
    end else if (xfer) begin
      m_data  <= enc_data;
      m_valid <= 1'b1;
      rd      <= disp_chain[NBYTES];
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef ENC_8B10B_WIDE_KERR_EN
  logic [NBYTES-1:0] k_err_c;

  // Legal control symbols: K28.0-7 plus K23.7, K27.7, K29.7, K30.7.
  always_comb begin
    k_err_c = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (k_a[i] && !((data_a[8*i +: 5] == 5'b11100) ||
                      (data_a[8*i +: 8] == 8'hF7) || (data_a[8*i +: 8] == 8'hFB) ||
                      (data_a[8*i +: 8] == 8'hFD) || (data_a[8*i +: 8] == 8'hFE)))
        k_err_c[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      m_k_err <= '0;
    else if (xfer)
      m_k_err <= k_err_c;
  end
`else
  assign m_k_err = '0;
`endif

endmodule

// Single-symbol 8b/10b encoder; datain = {k, HGFEDCBA}, dataout = {j,h,g,f,i,e,d,c,b,a}.
module encode (
  input  logic [8:0] datain,
  input  logic       dispin,
  output logic [9:0] dataout,
  output logic       dispout
);

  logic ai, bi, ci, di, ei, fi, gi, hi, ki;
  logic aeqb, ceqd, l22, l40, l04, l13, l31;
  logic a_o, b_o, c_o, d_o, e_o, i_o, f_o, g_o, h_o, j_o;
  logic pd1s6, nd1s6, ndos6, pdos6, alt7;
  logic nd1s4, pd1s4, ndos4, pdos4;
  logic compls6, disp6, compls4;

  assign {ki, hi, gi, fi, ei, di, ci, bi, ai} = datain;

  assign aeqb = (ai && bi) || (!ai && !bi);
  assign ceqd = (ci && di) || (!ci && !di);
  assign l22  = (ai && bi && !ci && !di) || (ci && di && !ai && !bi) || (!aeqb && !ceqd);
  assign l40  = ai && bi && ci && di;
  assign l04  = !ai && !bi && !ci && !di;
  assign l13  = (!aeqb && !ci && !di) || (!ceqd && !ai && !bi);
  assign l31  = (!aeqb && ci && di) || (!ceqd && ai && bi);

  assign a_o = ai;
  assign b_o = (bi && !l40) || l04;
  assign c_o = l04 || ci || (ei && di && !ci && !bi && !ai);
  assign d_o = di && !(ai && bi && ci);
  assign e_o = (ei || l13) && !(ei && di && !ci && !bi && !ai);
  assign i_o = (l22 && !ei) || (ei && !di && !ci && !(ai && bi)) || (ei && l40) ||
               (ki && ei && di && ci && !bi && !ai) || (ei && !di && ci && !bi && !ai);

  assign pd1s6 = (ei && di && !ci && !bi && !ai) || (!ei && !l22 && !l31);
  assign nd1s6 = ki || (ei && !l22 && !l13) || (!ei && !di && ci && bi && ai);
  assign ndos6 = pd1s6;
  assign pdos6 = ki || (ei && !l22 && !l13);

  // Alternate x.7 code avoids a run of five identical bits across the 6b/4b boundary.
  assign alt7 = fi && gi && hi && (ki || (dispin ? (!ei && di && l31) : (ei && !di && l13)));
  assign f_o  = fi && !alt7;
  assign g_o  = gi || (!fi && !gi && !hi);
  assign h_o  = hi;
  assign j_o  = (!hi && (gi ^ fi)) || alt7;

  assign nd1s4 = fi && gi;
  assign pd1s4 = (!fi && !gi) || (ki && ((fi && !gi) || (!fi && gi)));
  assign ndos4 = !fi && !gi;
  assign pdos4 = fi && gi && hi;

  assign compls6 = (pd1s6 && !dispin) || (nd1s6 && dispin);
  assign disp6   = dispin ^ (ndos6 || pdos6);
  assign compls4 = (pd1s4 && !disp6) || (nd1s4 && disp6);
  assign dispout = disp6 ^ (ndos4 || pdos4);

  assign dataout = {j_o ^ compls4, h_o ^ compls4, g_o ^ compls4, f_o ^ compls4,
                    i_o ^ compls6, e_o ^ compls6, d_o ^ compls6, c_o ^ compls6,
                    b_o ^ compls6, a_o ^ compls6};

endmodule
